m_axi_cmd_master: RTL and testbench

Single-outstanding AXI4 burst master that converts a simple command/stream interface into full AXI4 write (AW/W/B) and read (AR/R) transactions. It sits directly upstream of the AXI4 memory slave, driving its s_axi_* channels, and is used by test sequencers and the DMA front end to exercise and fill slave memory. One command is in flight at a time; completion is reported with a one-cycle done pulse carrying the worst response.

---
 rtl/m_axi_cmd_master_if.sv | 78 +++++++
 rtl/m_axi_cmd_master.sv | 227 ++++++++++++++++++++++
 tb/tb_m_axi_cmd_master.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/m_axi_cmd_master_if.sv
// AXI4 master-side bundle used by m_axi_cmd_master.
// Carries the AW, W, B, AR and R channels. The master modport drives the request
// channels and the B/R readies. The slave modport is the mirror view for the
// memory slave or a bench model.
interface m_axi_cmd_master_if #(
  parameter int unsigned ID_WIDTH   = 1,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32
);
  // Write address channel
  logic [ID_WIDTH-1:0]     awid;
  logic [ADDR_WIDTH-1:0]   awaddr;
  logic [7:0]              awlen;
  logic [2:0]              awsize;
  logic [1:0]              awburst;
  logic                    awlock;
  logic [3:0]              awcache;
  logic [2:0]              awprot;
  logic [3:0]              awqos;
  logic                    awvalid;
  logic                    awready;
  // Write data channel
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wlast;
  logic                    wvalid;
  logic                    wready;
  // Write response channel
  logic [ID_WIDTH-1:0]     bid;
  logic [1:0]              bresp;
  logic                    bvalid;
  logic                    bready;
  // Read address channel
  logic [ID_WIDTH-1:0]     arid;
  logic [ADDR_WIDTH-1:0]   araddr;
  logic [7:0]              arlen;
  logic [2:0]              arsize;
  logic [1:0]              arburst;
  logic                    arlock;
  logic [3:0]              arcache;
  logic [2:0]              arprot;
  logic [3:0]              arqos;
  logic                    arvalid;
  logic                    arready;
  // Read data channel
  logic [ID_WIDTH-1:0]     rid;
  logic [DATA_WIDTH-1:0]   rdata;
  logic [1:0]              rresp;
  logic                    rlast;
  logic                    rvalid;
  logic                    rready;

  modport master (
    output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awqos, awvalid,
    input  awready,
    output wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready,
    output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready
  );

  modport slave (
    input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awqos, awvalid,
    output awready,
    input  wdata, wstrb, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready,
    input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready
  );
endinterface

// File: rtl/m_axi_cmd_master.sv
// Single-outstanding AXI4 burst master.
// It turns one command (write/read, address, len, burst) into a full AXI4 write
// (AW/W/B) or read (AR/R) transaction.
// Ports:
//   m_axi_aclk, m_axi_areset : clock, synchronous active-high reset
//   cmd_*                    : command handshake, accepted only while cmd_ready
//   wr_*                     : write beat stream, passed to W during the data phase
//   rd_*                     : read beat stream, passed from R during the data phase
//   done, done_write, done_resp : one-cycle completion pulse with worst response
//   m_axi                    : AXI4 master bundle
module m_axi_cmd_master #(
  parameter int unsigned ID_WIDTH   = 1,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned AXI_ID     = 0
) (
  input  logic                    m_axi_aclk,
  input  logic                    m_axi_areset,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_write,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [7:0]              cmd_len,
  input  logic [1:0]              cmd_burst,
  input  logic [DATA_WIDTH-1:0]   wr_data,
  input  logic [DATA_WIDTH/8-1:0] wr_strb,
  input  logic                    wr_valid,
  output logic                    wr_ready,
  output logic [DATA_WIDTH-1:0]   rd_data,
  output logic                    rd_last,
  output logic                    rd_valid,
  input  logic                    rd_ready,
  output logic                    done,
  output logic                    done_write,
  output logic [1:0]              done_resp,
  m_axi_cmd_master_if.master      m_axi
);
  localparam int unsigned StrbW   = DATA_WIDTH / 8;
  localparam int unsigned AddrLsb = $clog2(StrbW);

  typedef enum logic [2:0] {
    StIdle, StCheck, StWaddr, StWdata, StWresp, StRaddr, StRdata, StDone
  } state_e;

  state_e                state_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [7:0]            len_q;
  logic [1:0]            burst_q;
  logic                  write_q;
  logic [7:0]            cnt_q;
  logic [1:0]            acc_q;
  logic                  cmd_ready_q, awvalid_q, arvalid_q, bready_q;
  logic                  done_q, done_write_q;
  logic [1:0]            done_resp_q;

  logic        w_hs, r_hs, beat_last, illegal, r_end;
  logic [16:0] span_end;
  logic [1:0]  r_resp_d;

  // Error ranking: SLVERR/DECERR dominate; OKAY and EXOKAY both rank as OKAY.
  function automatic logic [1:0] worst(input logic [1:0] a, input logic [1:0] b);
    if (a == 2'b11 || b == 2'b11) return 2'b11;
    if (a == 2'b10 || b == 2'b10) return 2'b10;
    return 2'b00;
  endfunction

  assign w_hs      = (state_q == StWdata) && wr_valid && m_axi.wready;
  assign r_hs      = (state_q == StRdata) && m_axi.rvalid && rd_ready;
  assign beat_last = (cnt_q == len_q);
  assign r_end     = m_axi.rlast || beat_last;

  // One past the last byte of an INCR burst, relative to its 4 KB page.
  assign span_end = 17'(addr_q[11:0]) + ((17'(len_q) + 17'd1) << AddrLsb);

  always_comb begin
    illegal = 1'b0;
    case (burst_q)
      2'b00:   illegal = 1'b0;
      2'b01:   illegal = span_end > 17'd4096;
      2'b10:   illegal = !(len_q inside {8'd1, 8'd3, 8'd7, 8'd15});
      default: illegal = 1'b1;
    endcase
  end

  // An rlast/beat-count disagreement is reported as SLVERR.
  assign r_resp_d = worst(acc_q, worst(m_axi.rresp,
                                       (m_axi.rlast != beat_last) ? 2'b10 : 2'b00));

  always_ff @(posedge m_axi_aclk) begin
    if (m_axi_areset) begin
      state_q      <= StIdle;
      addr_q       <= '0;
      len_q        <= '0;
      burst_q      <= '0;
      write_q      <= 1'b0;
      cnt_q        <= '0;
      acc_q        <= '0;
      cmd_ready_q  <= 1'b0;
      awvalid_q    <= 1'b0;
      arvalid_q    <= 1'b0;
      bready_q     <= 1'b0;
      done_q       <= 1'b0;
      done_write_q <= 1'b0;
      done_resp_q  <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          cmd_ready_q <= 1'b1;
          if (cmd_ready_q && cmd_valid) begin
            cmd_ready_q <= 1'b0;
            addr_q      <= cmd_addr & ~ADDR_WIDTH'(StrbW - 1);
            len_q       <= cmd_len;
            burst_q     <= cmd_burst;
            write_q     <= cmd_write;
            state_q     <= StCheck;
          end
        end
        StCheck: begin
          cnt_q <= '0;
          acc_q <= '0;
          if (illegal) begin
            done_q       <= 1'b1;
            done_write_q <= write_q;
            done_resp_q  <= 2'b10;
            state_q      <= StDone;
          end else if (write_q) begin
            awvalid_q <= 1'b1;
            state_q   <= StWaddr;
          end else begin
            arvalid_q <= 1'b1;
            state_q   <= StRaddr;
          end
        end
        StWaddr: begin
          if (m_axi.awready) begin
            awvalid_q <= 1'b0;
            state_q   <= StWdata;
          end
        end
        StWdata: begin
          if (w_hs) begin
            cnt_q <= cnt_q + 8'd1;
            if (beat_last) begin
              bready_q <= 1'b1;
              state_q  <= StWresp;
            end
          end
        end
        StWresp: begin
          if (m_axi.bvalid) begin
            bready_q     <= 1'b0;
            done_q       <= 1'b1;
            done_write_q <= 1'b1;
            done_resp_q  <= (m_axi.bid == ID_WIDTH'(AXI_ID)) ? m_axi.bresp : 2'b10;
            state_q      <= StDone;
          end
        end
        StRaddr: begin
          if (m_axi.arready) begin
            arvalid_q <= 1'b0;
            state_q   <= StRdata;
          end
        end
        StRdata: begin
          if (r_hs) begin
            cnt_q <= cnt_q + 8'd1;
            acc_q <= r_resp_d;
            if (r_end) begin
              done_q       <= 1'b1;
              done_write_q <= 1'b0;
              done_resp_q  <= r_resp_d;
              state_q      <= StDone;
            end
          end
        end
        StDone: begin
          done_q       <= 1'b0;
          done_write_q <= 1'b0;
          cmd_ready_q  <= 1'b1;
          state_q      <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign cmd_ready  = cmd_ready_q;
  assign done       = done_q;
  assign done_write = done_write_q;
  assign done_resp  = done_resp_q;

  assign m_axi.awid    = ID_WIDTH'(AXI_ID);
  assign m_axi.awaddr  = addr_q;
  assign m_axi.awlen   = len_q;
  assign m_axi.awsize  = 3'(AddrLsb);
  assign m_axi.awburst = burst_q;
  assign m_axi.awlock  = 1'b0;
  assign m_axi.awcache = 4'd0;
  assign m_axi.awprot  = 3'd0;
  assign m_axi.awqos   = 4'd0;
  assign m_axi.awvalid = awvalid_q;

  // W and R are combinational pass-throughs, live only in their data phase.
  assign m_axi.wdata  = wr_data;
  assign m_axi.wstrb  = wr_strb;
  assign m_axi.wlast  = (state_q == StWdata) && beat_last;
  assign m_axi.wvalid = (state_q == StWdata) && wr_valid;
  assign wr_ready     = (state_q == StWdata) && m_axi.wready;

  assign m_axi.bready = bready_q;

  assign m_axi.arid    = ID_WIDTH'(AXI_ID);
  assign m_axi.araddr  = addr_q;
  assign m_axi.arlen   = len_q;
  assign m_axi.arsize  = 3'(AddrLsb);
  assign m_axi.arburst = burst_q;
  assign m_axi.arlock  = 1'b0;
  assign m_axi.arcache = 4'd0;
  assign m_axi.arprot  = 3'd0;
  assign m_axi.arqos   = 4'd0;
  assign m_axi.arvalid = arvalid_q;

  assign m_axi.rready = (state_q == StRdata) && rd_ready;
  assign rd_valid     = (state_q == StRdata) && m_axi.rvalid;
  assign rd_data      = m_axi.rdata;
  assign rd_last      = m_axi.rlast;
endmodule

// File: tb/tb_m_axi_cmd_master.sv
// Directed bench for m_axi_cmd_master.
// A table of commands runs against a small scripted AXI slave.
// Each command checks the AXI fields, beat data, done timing and response.
// A reset-mid-write sequence follows.
module tb_m_axi_cmd_master;
  logic        clk = 1'b0;
  logic        areset = 1'b1;
  logic        cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
  logic [31:0] cmd_addr = '0;
  logic [7:0]  cmd_len = '0;
  logic [1:0]  cmd_burst = '0;
  logic [31:0] wr_data = '0;
  logic [3:0]  wr_strb = '0;
  logic        wr_valid = 1'b0, wr_ready;
  logic [31:0] rd_data;
  logic        rd_last, rd_valid, rd_ready = 1'b0;
  logic        done, done_write;
  logic [1:0]  done_resp;

  int checks = 0;
  int errors = 0;

  m_axi_cmd_master_if #(.ID_WIDTH(1), .DATA_WIDTH(32), .ADDR_WIDTH(32)) axi ();

  m_axi_cmd_master #(.ID_WIDTH(1), .DATA_WIDTH(32), .ADDR_WIDTH(32), .AXI_ID(0)) dut (
    .m_axi_aclk(clk), .m_axi_areset(areset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_burst(cmd_burst),
    .wr_data(wr_data), .wr_strb(wr_strb), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .rd_data(rd_data), .rd_last(rd_last), .rd_valid(rd_valid), .rd_ready(rd_ready),
    .done(done), .done_write(done_write), .done_resp(done_resp),
    .m_axi(axi)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        write;
    logic [31:0] addr;
    logic [7:0]  len;
    logic [1:0]  burst;
    int          aw_delay;   // cycles of awvalid before awready
    logic        w_toggle;   // wready alternates each cycle
    logic        bad_bid;
    int          err_beat;   // read beat carrying err_resp, -1 none
    logic [1:0]  err_resp;
    int          last_beat;  // read beat carrying rlast, > len means never
    int          rst_beat;   // write beat during which reset is raised, -1 none
    logic [31:0] exp_addr;
    logic        exp_illegal;
    logic [1:0]  exp_resp;
    int          exp_done_cyc;
  } vec_t;

  vec_t vecs[16];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic slave_idle();
    axi.awready = 1'b0; axi.wready = 1'b0; axi.bvalid = 1'b0; axi.bid = 1'b0;
    axi.bresp = 2'b00; axi.arready = 1'b0; axi.rvalid = 1'b0; axi.rid = 1'b0;
    axi.rdata = '0; axi.rresp = 2'b00; axi.rlast = 1'b0;
    wr_valid = 1'b0; rd_ready = 1'b0;
  endtask

  task automatic run_cmd(input vec_t v);
    int cyc, aw_seen, wbeat, rsent, nbeats, done_cyc;
    logic any_valid, aw_done, ar_done, b_done, got_done, dw_seen;
    logic [1:0] resp_seen;
    cyc = 0; aw_seen = 0; wbeat = 0; rsent = 0; done_cyc = 0;
    any_valid = 0; aw_done = 0; ar_done = 0; b_done = 0; got_done = 0; dw_seen = 0;
    resp_seen = 2'b00;
    nbeats = (v.last_beat <= int'(v.len)) ? v.last_beat + 1 : int'(v.len) + 1;

    @(negedge clk);
    slave_idle();
    cmd_valid = 1'b1; cmd_write = v.write; cmd_addr = v.addr;
    cmd_len = v.len; cmd_burst = v.burst;
    #1;
    for (int i = 0; i < 20 && !cmd_ready; i++) begin
      @(negedge clk); #1;
    end
    chk("cmd_accept", cmd_ready, 1);
    @(negedge clk);
    cmd_valid = 1'b0;
    if (!cmd_ready && checks < 0) return;
    cyc = 1;
    while (cyc < 300 && !got_done) begin
      axi.awready = axi.awvalid && (aw_seen >= v.aw_delay);
      axi.wready  = v.w_toggle ? cyc[0] : 1'b1;
      wr_valid    = 1'b1;
      wr_strb     = 4'hF;
      wr_data     = 32'(32'h11 * (wbeat + 1));
      axi.bvalid  = v.write && !b_done && (wbeat == int'(v.len) + 1);
      axi.bid     = v.bad_bid;
      axi.arready = axi.arvalid;
      axi.rvalid  = ar_done && (rsent < nbeats);
      axi.rdata   = 32'hA000_0000 + 32'(rsent);
      axi.rresp   = (rsent == v.err_beat) ? v.err_resp : 2'b00;
      axi.rlast   = (rsent == v.last_beat);
      rd_ready    = 1'b1;
      #1;
      if (axi.awvalid || axi.arvalid || axi.wvalid) any_valid = 1'b1;
      if (axi.awvalid) begin
        chk("awaddr", axi.awaddr, v.exp_addr);
        chk("aw_len_size_burst_id", {axi.awlen, axi.awsize, axi.awburst, axi.awid},
            {v.len, 3'd2, v.burst, 1'b0});
        aw_seen++;
        if (axi.awready) aw_done = 1'b1;
      end
      if (axi.arvalid) begin
        chk("araddr", axi.araddr, v.exp_addr);
        chk("ar_len_size_burst_id", {axi.arlen, axi.arsize, axi.arburst, axi.arid},
            {v.len, 3'd2, v.burst, 1'b0});
        if (axi.arready) ar_done = 1'b1;
      end
      if (aw_done && !axi.awvalid && wbeat <= int'(v.len)) begin
        chk("wr_ready_mirror", wr_ready, axi.wready);
        chk("wvalid_pass", axi.wvalid, 1);
      end
      if (axi.wvalid && axi.wready) begin
        if (wbeat == v.rst_beat) begin
          // Reset lands on the same edge as this beat's handshake.
          areset = 1'b1;
          @(negedge clk); #1;
          chk("rst_outputs_zero", {axi.awvalid, axi.wvalid, axi.bready, axi.arvalid,
                                   axi.rready, wr_ready, done, cmd_ready}, 0);
          areset = 1'b0;
          @(negedge clk); #1;
          chk("cmd_ready_after_rst", cmd_ready, 1);
          slave_idle();
          return;
        end
        chk("wdata", axi.wdata, 32'(32'h11 * (wbeat + 1)));
        chk("wstrb", axi.wstrb, 4'hF);
        chk("wlast", axi.wlast, wbeat == int'(v.len));
        wbeat++;
      end
      if (axi.bvalid && axi.bready) b_done = 1'b1;
      if (axi.rvalid && axi.rready) begin
        chk("rd_beat", {rd_valid, rd_data, rd_last},
            {1'b1, 32'hA000_0000 + 32'(rsent), rsent == v.last_beat});
        rsent++;
      end
      if (done) begin
        got_done = 1'b1; done_cyc = cyc; resp_seen = done_resp; dw_seen = done_write;
      end
      @(negedge clk);
      cyc++;
    end
    chk("done_seen", got_done, 1);
    chk("done_resp", resp_seen, v.exp_resp);
    chk("done_write", dw_seen, v.write);
    if (v.exp_done_cyc != 0) chk("done_cycle", done_cyc, v.exp_done_cyc);
    if (v.exp_illegal) chk("no_axi_valids", any_valid, 0);
    else if (v.write) chk("w_beats", wbeat, int'(v.len) + 1);
    else chk("r_beats", rsent, nbeats);
    slave_idle();
    #1;
    chk("cmd_ready_after_done", {cmd_ready, done}, 2'b10);
  endtask

  initial begin
    //            wr addr           len   burst dly tog bid eb  er     lb   rb  exp_addr  ill resp cyc
    vecs[0]  = '{1, 32'h4000_0010, 8'd3,  2'b01, 0, 0, 0, -1, 2'b00, 3,  -1, 32'h4000_0010, 0, 2'b00, 8};
    vecs[1]  = '{0, 32'h4000_000C, 8'd3,  2'b10, 0, 0, 0, -1, 2'b00, 3,  -1, 32'h4000_000C, 0, 2'b00, 7};
    vecs[2]  = '{1, 32'h4000_0100, 8'd3,  2'b01, 5, 1, 0, -1, 2'b00, 3,  -1, 32'h4000_0100, 0, 2'b00, 17};
    vecs[3]  = '{1, 32'h4000_0FF0, 8'd15, 2'b01, 0, 0, 0, -1, 2'b00, 15, -1, 32'h4000_0FF0, 1, 2'b10, 2};
    vecs[4]  = '{0, 32'h4000_0000, 8'd2,  2'b10, 0, 0, 0, -1, 2'b00, 2,  -1, 32'h4000_0000, 1, 2'b10, 2};
    vecs[5]  = '{1, 32'h4000_0000, 8'd0,  2'b11, 0, 0, 0, -1, 2'b00, 0,  -1, 32'h4000_0000, 1, 2'b10, 2};
    vecs[6]  = '{0, 32'h4000_0200, 8'd3,  2'b01, 0, 0, 0, 1,  2'b10, 3,  -1, 32'h4000_0200, 0, 2'b10, 7};
    vecs[7]  = '{0, 32'h4000_0300, 8'd3,  2'b01, 0, 0, 0, -1, 2'b00, 1,  -1, 32'h4000_0300, 0, 2'b10, 5};
    vecs[8]  = '{0, 32'h4000_0400, 8'd3,  2'b01, 0, 0, 0, 0,  2'b11, 1,  -1, 32'h4000_0400, 0, 2'b11, 5};
    vecs[9]  = '{0, 32'h4000_0FC0, 8'd15, 2'b01, 0, 0, 0, -1, 2'b00, 15, -1, 32'h4000_0FC0, 0, 2'b00, 19};
    vecs[10] = '{1, 32'h4000_0FFC, 8'd2,  2'b00, 0, 0, 0, -1, 2'b00, 2,  -1, 32'h4000_0FFC, 0, 2'b00, 7};
    vecs[11] = '{1, 32'h4000_0500, 8'd0,  2'b01, 0, 0, 1, -1, 2'b00, 0,  -1, 32'h4000_0500, 0, 2'b10, 5};
    vecs[12] = '{0, 32'h4000_0600, 8'd1,  2'b01, 0, 0, 0, -1, 2'b00, 99, -1, 32'h4000_0600, 0, 2'b10, 5};
    vecs[13] = '{1, 32'h4000_0700, 8'd3,  2'b01, 0, 0, 0, -1, 2'b00, 3,  1,  32'h4000_0700, 0, 2'b00, 0};
    vecs[14] = '{1, 32'h4000_0013, 8'd1,  2'b01, 0, 0, 0, -1, 2'b00, 1,  -1, 32'h4000_0010, 0, 2'b00, 6};
    vecs[15] = '{1, 32'h4000_0020, 8'd0,  2'b01, 0, 0, 0, -1, 2'b00, 0,  -1, 32'h4000_0020, 0, 2'b00, 5};

    slave_idle();
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    chk("reset_state", {cmd_ready, done, done_write, done_resp, axi.awvalid, axi.wvalid,
                        axi.bready, axi.arvalid, axi.rready, wr_ready, rd_valid}, 0);
    @(negedge clk);
    areset = 1'b0;

    for (int i = 0; i < 16; i++) run_cmd(vecs[i]);

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end
endmodule
